// File: rtl/register.sv
//------------------------------------------------------------------------------
// Module  : register
// Brief   : WIDTH-bit load-enabled storage register with zero/sign flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic [WIDTH-1:0] data_out,
  output logic             is_zero,
  output logic             is_negative
);

  logic [WIDTH-1:0] r_data;

  // Reset is active-low and wins over load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= RESET_VALUE;
    end else if (load) begin
      r_data <= data_in;
    end
  end

  assign data_out    = r_data;
  assign is_zero     = (r_data == '0);
  assign is_negative = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_register.sv
//------------------------------------------------------------------------------
// Module  : tb_register
// Brief   : Self-checking bench for register against a value-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_register;

  localparam int         C_WIDTH = 8;
  localparam logic [7:0] C_RESET = 8'h00;

  logic               clk;
  logic               reset;
  logic [C_WIDTH-1:0] data_in;
  logic               load;
  logic [C_WIDTH-1:0] data_out;
  logic               is_zero;
  logic               is_negative;

  int total;
  int bad;

  // Reference: the value the register should hold, and whether it is defined yet.
  int unsigned model;
  bit          known;

  register #(
    .WIDTH       (C_WIDTH),
    .RESET_VALUE (C_RESET)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load        (load),
    .data_out    (data_out),
    .is_zero     (is_zero),
    .is_negative (is_negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 64'(data_out), 64'(model));
    check({tag, ".is_zero"}, 64'(is_zero), 64'(model == 0));
    check({tag, ".is_negative"}, 64'(is_negative), 64'(model >= (1 << (C_WIDTH - 1))));
  endtask

  // Drive inputs after a falling edge, confirm nothing moves before the rising
  // edge, then apply the spec rules to the model and compare after the edge.
  task automatic step(input string tag, input logic rst_n, input logic ld, input logic [C_WIDTH-1:0] din);
    @(negedge clk);
    reset   = rst_n;
    load    = ld;
    data_in = din;
    #1;
    if (known) check_all({tag, ".pre"});
    @(posedge clk);
    if (!rst_n) begin
      model = C_RESET;
      known = 1'b1;
    end else if (ld) begin
      model = din;
    end
    #1;
    if (known) check_all(tag);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    model   = 0;
    known   = 1'b0;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;

    step("reset",      1'b0, 1'b0, 8'hEA);
    step("load_ea",    1'b1, 1'b1, 8'hEA);
    step("hold1",      1'b1, 1'b0, 8'h15);
    step("hold2",      1'b1, 1'b0, 8'h15);
    step("rst_prio",   1'b0, 1'b1, 8'h55);
    step("b2b_01",     1'b1, 1'b1, 8'h01);
    step("b2b_80",     1'b1, 1'b1, 8'h80);
    step("b2b_00",     1'b1, 1'b1, 8'h00);
    step("load_7f",    1'b1, 1'b1, 8'h7F);
    step("load_ff",    1'b1, 1'b1, 8'hFF);

    // Reset glitch between edges must not reach the stored value.
    @(negedge clk);
    load    = 1'b0;
    reset   = 1'b0;
    #2;
    check_all("glitch.low");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("glitch.after");

    step("rst_release", 1'b0, 1'b0, 8'h33);
    step("first_load",  1'b1, 1'b1, 8'hC3);

    for (int i = 0; i < 300; i++) begin
      logic [C_WIDTH-1:0] d;
      case ($urandom_range(0, 7))
        0:       d = 8'h00;
        1:       d = 8'h80;
        2:       d = 8'hFF;
        default: d = C_WIDTH'($urandom);
      endcase
      step("rand", ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
